// File: rtl/matmul_systolic_array.sv
// -----------------------------------------------------------------------------
// matmul_systolic_array
//
// Output-stationary MAX_DIM x MAX_DIM systolic MAC grid. Skewed A lanes enter
// at column 0 and shift right one PE per cycle. Skewed B lanes enter at row 0
// and shift down one PE per cycle. Each PE keeps its own accumulator, so
// C = A x B builds up in place over a fixed RUN_CYCLES window.
//
// Ports:
//   clk_i        in   clock, all state updates on the rising edge
//   rst_i        in   asynchronous, active-high reset
//   start_i      in   operation start level (IDLE->RUN; DONE->IDLE when low)
//   in_vector_a  in   lane i feeds row i, column 0
//   in_vector_b  in   lane j feeds column j, row 0
//   c_flat_o     out  C[i][j] at bits [(i*MAX_DIM+j+1)*BUS_WIDTH-1 -: BUS_WIDTH]
//   busy_o       out  high while accumulating (RUN)
//   done_o       out  high while the result is complete (DONE)
// -----------------------------------------------------------------------------
module matmul_systolic_array #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int RUN_CYCLES = 4 * (BUS_WIDTH / DATA_WIDTH)
) (
  input  logic                                                         clk_i,
  input  logic                                                         rst_i,
  input  logic                                                         start_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0]                 in_vector_a,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0]                 in_vector_b,
  output logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] c_flat_o,
  output logic                                                         busy_o,
  output logic                                                         done_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int CNT_W   = $clog2(RUN_CYCLES + 1);
  localparam int PROD_W  = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]  a_q   [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0]  a_d   [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0]  b_q   [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0]  b_d   [MAX_DIM][MAX_DIM];
  logic signed [BUS_WIDTH-1:0]   acc_q [MAX_DIM][MAX_DIM];
  logic signed [BUS_WIDTH-1:0]   acc_d [MAX_DIM][MAX_DIM];

  // One PE step: full-precision signed product, sign-extended, wrapping add.
  function automatic logic signed [BUS_WIDTH-1:0] mac_step(
    input logic signed [BUS_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(a) * PROD_W'(b);
    return acc + BUS_WIDTH'(prod);
  endfunction

  // Next-state, operand shifting and accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // Clear the whole grid so a new run never sees stale operands.
          for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 0; j < MAX_DIM; j++) begin
              a_d[i][j]   = '0;
              b_d[i][j]   = '0;
              acc_d[i][j] = '0;
            end
          end
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < MAX_DIM; i++) begin
          for (int j = 0; j < MAX_DIM; j++) begin
            // Uses pre-edge operand registers, so the MAC sees the pair
            // that currently sits in this PE, not the one arriving.
            acc_d[i][j] = mac_step(acc_q[i][j], a_q[i][j], b_q[i][j]);
            if (j == 0) begin
              a_d[i][j] = in_vector_a[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH];
            end else begin
              a_d[i][j] = a_q[i][j-1];
            end
            if (i == 0) begin
              b_d[i][j] = in_vector_b[(j+1)*DATA_WIDTH-1 -: DATA_WIDTH];
            end else begin
              b_d[i][j] = b_q[i-1][j];
            end
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        // Grid is frozen; leave only once start_i has been released so a
        // held start level cannot retrigger.
        if (start_i) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, operand and accumulator registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Flatten the accumulator array onto the result bus.
  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
      assign c_flat_o[(gi*MAX_DIM+gj+1)*BUS_WIDTH-1 -: BUS_WIDTH] = acc_q[gi][gj];
    end
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_matmul_systolic_array.sv
// -----------------------------------------------------------------------------
// tb_matmul_systolic_array
//
// Directed bench for matmul_systolic_array with hand-computed expected grids.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_matmul_systolic_array;

  localparam int DW = 8;
  localparam int BW = 32;
  localparam int MD = 4;
  localparam int RC = 16;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [MD*DW-1:0]  in_a;
  logic [MD*DW-1:0]  in_b;
  logic [BW*MD*MD-1:0] c_flat;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  logic [MD*DW-1:0] a_seq [RC];
  logic [MD*DW-1:0] b_seq [RC];
  int               a_m   [MD][MD];
  int               b_m   [MD][MD];
  logic [BW-1:0]    exp_c [MD][MD];

  matmul_systolic_array dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .in_vector_a (in_a),
    .in_vector_b (in_b),
    .c_flat_o    (c_flat),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] c_elem(input int i, input int j);
    return c_flat[(i*MD+j+1)*BW-1 -: BW];
  endfunction

  task automatic check_grid(input string tag);
    for (int i = 0; i < MD; i++) begin
      for (int j = 0; j < MD; j++) begin
        check_eq($sformatf("%s C[%0d][%0d]", tag, i, j), c_elem(i, j), exp_c[i][j]);
      end
    end
  endtask

  task automatic set_exp_zero();
    for (int i = 0; i < MD; i++) begin
      for (int j = 0; j < MD; j++) begin
        exp_c[i][j] = 32'd0;
      end
    end
  endtask

  task automatic clear_seq();
    for (int c = 0; c < RC; c++) begin
      a_seq[c] = '0;
      b_seq[c] = '0;
    end
  endtask

  task automatic zero_mats();
    for (int i = 0; i < MD; i++) begin
      for (int j = 0; j < MD; j++) begin
        a_m[i][j] = 0;
        b_m[i][j] = 0;
      end
    end
  endtask

  // Skew the matrices the way the upstream shifter does: A[i][k] on lane i
  // at cycle k+i, B[k][j] on lane j at cycle k+j.
  task automatic load_skew();
    clear_seq();
    for (int c = 0; c < RC; c++) begin
      for (int l = 0; l < MD; l++) begin
        int k;
        k = c - l;
        if (k >= 0 && k < MD) begin
          a_seq[c][l*DW +: DW] = DW'(a_m[l][k]);
          b_seq[c][l*DW +: DW] = DW'(b_m[k][l]);
        end
      end
    end
  endtask

  // Start from IDLE, stream a_seq/b_seq for the whole window, end in DONE.
  task automatic run_op(input bit toggle_start);
    start_i = 1'b1;
    in_a    = '1;   // must be ignored on the IDLE->RUN edge
    in_b    = '1;
    @(negedge clk);
    check_eq("run busy after start", {31'd0, busy}, 32'd1);
    check_eq("run cleared C00", c_elem(0, 0), 32'd0);
    for (int c = 0; c < RC; c++) begin
      in_a = a_seq[c];
      in_b = b_seq[c];
      if (toggle_start) begin
        start_i = (c % 2 == 1);
      end
      @(negedge clk);
      if (c == RC - 2) begin
        check_eq("busy at run cycle 15", {31'd0, busy}, 32'd1);
        check_eq("done at run cycle 15", {31'd0, done}, 32'd0);
      end
    end
    check_eq("done after 16 cycles", {31'd0, done}, 32'd1);
    check_eq("busy after 16 cycles", {31'd0, busy}, 32'd0);
    in_a = '0;
    in_b = '0;
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    in_a    = '0;
    in_b    = '0;
    repeat (2) @(negedge clk);
    set_exp_zero();
    check_grid("reset");
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Single meeting at PE(0,0): 3*5.
    clear_seq();
    a_seq[0][7:0] = 8'd3;
    b_seq[0][7:0] = 8'd5;
    run_op(1'b0);
    set_exp_zero();
    exp_c[0][0] = 32'd15;
    check_grid("single");
    start_i = 1'b0;
    @(negedge clk);
    check_eq("single back to idle", {31'd0, done}, 32'd0);

    // Skew mismatch: A lane1 and B lane2 never share PE(1,2); start toggles.
    clear_seq();
    a_seq[0][15:8]  = 8'd2;
    b_seq[0][23:16] = 8'd7;
    run_op(1'b1);
    set_exp_zero();
    check_grid("skew");
    start_i = 1'b0;
    @(negedge clk);

    // Full 4x4, A = 1..16 row-major, B = identity.
    zero_mats();
    for (int i = 0; i < MD; i++) begin
      for (int k = 0; k < MD; k++) begin
        a_m[i][k] = i * MD + k + 1;
      end
      b_m[i][i] = 1;
    end
    load_skew();
    run_op(1'b0);
    for (int i = 0; i < MD; i++) begin
      for (int j = 0; j < MD; j++) begin
        exp_c[i][j] = 32'(i * MD + j + 1);
      end
    end
    check_grid("full");

    // Start held high: stay in DONE, inputs ignored, grid frozen.
    start_i = 1'b1;
    in_a    = 32'h7F7F7F7F;
    in_b    = 32'h7F7F7F7F;
    repeat (3) @(negedge clk);
    check_eq("held done", {31'd0, done}, 32'd1);
    check_eq("held busy", {31'd0, busy}, 32'd0);
    check_grid("held");
    start_i = 1'b0;
    @(negedge clk);
    check_eq("idle done", {31'd0, done}, 32'd0);
    check_eq("idle busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    check_grid("idle hold");

    // Retrigger: grid clears on the start edge.
    start_i = 1'b1;
    in_a    = '0;
    in_b    = '0;
    @(negedge clk);
    check_eq("retrigger busy", {31'd0, busy}, 32'd1);
    check_eq("retrigger done", {31'd0, done}, 32'd0);
    set_exp_zero();
    check_grid("retrigger");

    // Reset asserted after RUN cycle 7 clears everything without a clock edge.
    for (int c = 0; c < 7; c++) begin
      in_a = a_seq[c];
      in_b = b_seq[c];
      @(negedge clk);
    end
    check_eq("pre-reset C00", c_elem(0, 0), 32'd1);
    check_eq("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_i = 1'b1;
    #1;
    set_exp_zero();
    check_grid("async reset");
    check_eq("async reset busy", {31'd0, busy}, 32'd0);
    check_eq("async reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_i   = 1'b0;
    start_i = 1'b0;
    in_a    = '0;
    in_b    = '0;
    @(negedge clk);
    check_eq("post-reset idle", {31'd0, busy}, 32'd0);

    // Signed partial 2x3 x 3x2, zero padded.
    zero_mats();
    a_m[0][0] = -1;   a_m[0][1] = 2;    a_m[0][2] = 3;
    a_m[1][0] = 4;    a_m[1][1] = -128; a_m[1][2] = 0;
    b_m[0][0] = -128; b_m[0][1] = 1;
    b_m[1][0] = 2;    b_m[1][1] = 2;
    b_m[2][0] = 3;    b_m[2][1] = -1;
    load_skew();
    run_op(1'b0);
    set_exp_zero();
    exp_c[0][0] = 32'd141;
    exp_c[0][1] = 32'd0;
    exp_c[1][0] = 32'hFFFFFD00;
    exp_c[1][1] = 32'hFFFFFF04;
    check_grid("signed");
    start_i = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
